uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one uart_tx byte transmitter between NUM_REQ byte producers, such as button handlers, status reporters and debug taps.
- Each requester offers a byte with a valid/ready handshake.
- The block drives the transmitter's data_in and send inputs and uses its busy output to sequence one byte at a time.
- It sits in top between the requesters and uart_tx.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx byte transmitter between NUM_REQ byte producers using
// round-robin arbitration. Each producer offers a byte with a valid/ready
// handshake; the arbiter latches the winning byte, pulses the transmitter's
// send input for one cycle and then follows its busy output until the byte
// has gone out, so only one byte is ever in flight.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   req_valid    per-requester byte offered
//   req_data     per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot grant, combinational, only while idle
//   tx_data      byte presented to uart_tx data_in, held until next grant
//   tx_send      single-cycle start pulse to uart_tx send
//   tx_busy      busy flag from uart_tx
//   grant_id     index of the most recently granted requester
//   active       high from grant until the byte is complete
//   err_timeout  one-cycle pulse when tx_busy never rose after a send
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cand_idx;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   next_ptr;
  logic              any_valid;
  logic              grant;
  logic [CNT_W-1:0]  wait_cnt;

  // Round-robin search: rr_ptr is the requester with highest priority this
  // cycle (one past the last grant, 0 after reset). Walking offsets from the
  // top down lets the smallest offset overwrite the others and win.
  always_comb begin
    winner    = '0;
    cand_idx  = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand_idx]) begin
        winner    = cand_idx;
        any_valid = 1'b1;
      end
    end
    next_ptr = ID_W'((int'(winner) + 1) % NUM_REQ);
  end

  // A grant is only offered while idle and the transmitter is free, so a
  // valid arriving mid-transfer simply waits here.
  assign grant     = (state == IDLE) && !tx_busy && any_valid;
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  // Main sequencer. tx_send is registered: it rises on the grant edge so it
  // is high for exactly the SEND cycle. The timeout counter counts
  // consecutive low-busy cycles in WAIT_BUSY and gives up on the
  // ACK_TIMEOUT-th one, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data  <= req_data[winner*DATA_W +: DATA_W];
            grant_id <= winner;
            rr_ptr   <= next_ptr;
            active   <= 1'b1;
            tx_send  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_send  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            active      <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8,
// ACK_TIMEOUT=16). A small uart_tx stand-in raises busy one cycle after a
// send and holds it for a 10-cycle frame; it can also be forced low or high.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int FRAME_CYC   = 10;

  localparam int MODE_MODEL = 0;
  localparam int MODE_LOW   = 1;
  localparam int MODE_HIGH  = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_send;
  logic                       tx_busy;
  logic [1:0]                 grant_id;
  logic                       active;
  logic                       err_timeout;

  int checks = 0;
  int errors = 0;

  int mode = MODE_MODEL;
  int frame_left = 0;
  logic send_pend = 1'b0;

  logic [9:0] send_q[$];
  logic prev_send = 1'b0;
  int overlap = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[8];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx stand-in: a send seen after one edge raises busy after the next
  // edge, and busy then stays high for FRAME_CYC cycles.
  always @(posedge clk) begin
    #1;
    if (mode == MODE_MODEL) begin
      if (frame_left > 0) begin
        frame_left = frame_left - 1;
        if (frame_left == 0) tx_busy = 1'b0;
      end else if (send_pend) begin
        send_pend  = 1'b0;
        tx_busy    = 1'b1;
        frame_left = FRAME_CYC;
      end
      if (tx_send) send_pend = 1'b1;
    end
  end

  // Records every send pulse and flags sends that overlap busy or repeat
  // on consecutive cycles.
  always @(negedge clk) begin
    if (tx_send) begin
      send_q.push_back({grant_id, tx_data});
      if (tx_busy) overlap = overlap + 1;
      if (prev_send) overlap = overlap + 1;
    end
    prev_send = tx_send;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
    @(posedge clk);
    #1;
    req_valid = valid;
    req_data  = data;
  endtask

  task automatic dropValid();
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitActiveLow(input string name);
    int n = 0;
    @(negedge clk);
    while (active && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, active}, 32'd0);
  endtask

  task automatic waitSends(input int count);
    int n = 0;
    while (send_q.size() < count && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One complete single-byte transaction from the vector table.
  task automatic runVector(input int i);
    applyStimulus(vecs[i].valid, vecs[i].data);
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_ready});
    dropValid();
    @(negedge clk);
    checkOutput($sformatf("v%0d_send", i), {31'd0, tx_send}, 32'd1);
    checkOutput($sformatf("v%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_data});
    checkOutput($sformatf("v%0d_id", i), {30'd0, grant_id}, {30'd0, vecs[i].exp_id});
    checkOutput($sformatf("v%0d_active", i), {31'd0, active}, 32'd1);
    @(negedge clk);
    checkOutput($sformatf("v%0d_send_once", i), {31'd0, tx_send}, 32'd0);
    waitActiveLow($sformatf("v%0d_active_fall", i));
  endtask

  initial begin
    int n;
    int err_cnt;
    int err_at;
    logic act16;
    logic act_err;
    logic blocked;
    logic [7:0] t2_data[5];
    logic [1:0] t2_id[5];
    logic [7:0] t3_data[3];
    logic [1:0] t3_id[3];

    // Hand-computed round-robin sequence; pointer starts at 0 after reset.
    vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[2] = '{4'b0001, 32'h44332211, 4'b0001, 2'd0, 8'h11};
    vecs[3] = '{4'b1001, 32'hDDCCBBAA, 4'b1000, 2'd3, 8'hDD};
    vecs[4] = '{4'b1010, 32'h87654321, 4'b0010, 2'd1, 8'h43};
    vecs[5] = '{4'b0110, 32'h0F1E2D3C, 4'b0100, 2'd2, 8'h1E};
    vecs[6] = '{4'b0011, 32'h55AA66BB, 4'b0001, 2'd0, 8'hBB};
    vecs[7] = '{4'b0100, 32'hC0FFEE00, 4'b0100, 2'd2, 8'hFF};

    t2_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    t2_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    t3_data = '{8'hD3, 8'hA0, 8'hB1};
    t3_id   = '{2'd3, 2'd0, 2'd1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_send", {31'd0, tx_send}, 32'd0);
    checkOutput("rst_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_id", {30'd0, grant_id}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_err", {31'd0, err_timeout}, 32'd0);
    checkOutput("rst_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] table-driven transactions");
    for (int i = 0; i < 8; i++) runVector(i);

    $display("[TB] continuous valid 1011 after grant 2");
    send_q.delete();
    applyStimulus(4'b1011, 32'hD3C2B1A0);
    waitSends(3);
    dropValid();
    waitActiveLow("t3_active_fall");
    repeat (3) @(negedge clk);
    checkOutput("t3_count", send_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < send_q.size(); i++) begin
      checkOutput($sformatf("t3_id%0d", i), {30'd0, send_q[i][9:8]}, {30'd0, t3_id[i]});
      checkOutput($sformatf("t3_data%0d", i), {24'd0, send_q[i][7:0]}, {24'd0, t3_data[i]});
    end

    $display("[TB] all four requesters continuously valid");
    doReset();
    send_q.delete();
    overlap = 0;
    applyStimulus(4'b1111, 32'h13121110);
    waitSends(5);
    dropValid();
    waitActiveLow("t2_active_fall");
    repeat (3) @(negedge clk);
    checkOutput("t2_count", send_q.size(), 32'd5);
    checkOutput("t2_overlap", overlap, 32'd0);
    for (int i = 0; i < 5 && i < send_q.size(); i++) begin
      checkOutput($sformatf("t2_id%0d", i), {30'd0, send_q[i][9:8]}, {30'd0, t2_id[i]});
      checkOutput($sformatf("t2_data%0d", i), {24'd0, send_q[i][7:0]}, {24'd0, t2_data[i]});
    end

    $display("[TB] busy never rises");
    @(posedge clk);
    #1;
    mode    = MODE_LOW;
    tx_busy = 1'b0;
    applyStimulus(4'b0010, 32'h00007700);
    @(negedge clk);
    checkOutput("t4_ready", {28'd0, req_ready}, 32'h2);
    dropValid();
    @(negedge clk);
    checkOutput("t4_send", {31'd0, tx_send}, 32'd1);
    checkOutput("t4_data", {24'd0, tx_data}, 32'h77);
    err_cnt = 0;
    err_at  = 0;
    act16   = 1'b0;
    act_err = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 16) act16 = active;
      if (err_timeout) begin
        err_cnt = err_cnt + 1;
        err_at  = k;
        act_err = active;
      end
    end
    checkOutput("t4_err_count", err_cnt, 32'd1);
    checkOutput("t4_err_at", err_at, 32'd17);
    checkOutput("t4_active_before", {31'd0, act16}, 32'd1);
    checkOutput("t4_active_at_err", {31'd0, act_err}, 32'd0);
    applyStimulus(4'b0001, 32'h000000C3);
    @(negedge clk);
    checkOutput("t4_ready2", {28'd0, req_ready}, 32'h1);
    dropValid();
    @(negedge clk);
    checkOutput("t4_send2", {31'd0, tx_send}, 32'd1);
    checkOutput("t4_data2", {24'd0, tx_data}, 32'hC3);
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_err2", {31'd0, err_timeout}, 32'd1);

    $display("[TB] busy held high externally");
    @(posedge clk);
    #1;
    mode    = MODE_HIGH;
    tx_busy = 1'b1;
    applyStimulus(4'b0100, 32'h00990000);
    blocked = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != '0 || tx_send) blocked = 1'b1;
    end
    checkOutput("t5_blocked", {31'd0, blocked}, 32'd0);
    @(posedge clk);
    #1;
    mode    = MODE_MODEL;
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("t5_ready", {28'd0, req_ready}, 32'h4);
    dropValid();
    @(negedge clk);
    checkOutput("t5_send", {31'd0, tx_send}, 32'd1);
    checkOutput("t5_id", {30'd0, grant_id}, 32'd2);
    checkOutput("t5_data", {24'd0, tx_data}, 32'h99);
    waitActiveLow("t5_active_fall");

    $display("[TB] reset during WAIT_DONE");
    applyStimulus(4'b0010, 32'h44332211);
    @(negedge clk);
    checkOutput("t6_ready", {28'd0, req_ready}, 32'h2);
    dropValid();
    @(negedge clk);
    checkOutput("t6_id", {30'd0, grant_id}, 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b1010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_send", {31'd0, tx_send}, 32'd0);
    checkOutput("t6_rst_data", {24'd0, tx_data}, 32'd0);
    checkOutput("t6_rst_id", {30'd0, grant_id}, 32'd0);
    checkOutput("t6_rst_active", {31'd0, active}, 32'd0);
    checkOutput("t6_rst_err", {31'd0, err_timeout}, 32'd0);
    checkOutput("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_regrant_ready", {28'd0, req_ready}, 32'h2);
    dropValid();
    @(negedge clk);
    checkOutput("t6_regrant_send", {31'd0, tx_send}, 32'd1);
    checkOutput("t6_regrant_id", {30'd0, grant_id}, 32'd1);
    checkOutput("t6_regrant_data", {24'd0, tx_data}, 32'h22);
    waitActiveLow("t6_active_fall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
